// File: rtl/tab_table_loader.sv
// rtl/tab_table_loader.sv - stream-loaded tabulation-hash table with combinational lookup
module tab_table_loader #(
    parameter int Nloc     = 256,
    parameter int Dbits    = 32,
    parameter     initfile = "init.mem",
    parameter logic [Dbits-1:0] init_image [Nloc] = '{default: '0}
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [Dbits-1:0]         in_data,
    output logic                     in_ready,
    output logic                     loaded,
    output logic [$clog2(Nloc):0]    wr_count,
    output logic                     overrun,
    input  logic [$clog2(Nloc)-1:0]  readAddr,
    output logic [Dbits-1:0]         dataOut1
);
    localparam int Abits = $clog2(Nloc);
    localparam logic [Abits:0] last_idx = (Abits+1)'(Nloc - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    state_t state;

    logic [Dbits-1:0] tab_mem [Nloc];

`ifdef TAB_TABLE_INIT_EN
    initial begin
        for (int i = 0; i < Nloc; i++) begin
            tab_mem[i] = init_image[i];
        end
    end
`endif

    always @(posedge clock) begin
        if (!reset && state == LOAD && in_valid) begin
            tab_mem[wr_count[Abits-1:0]] <= in_data;
        end
    end

    assign dataOut1 = tab_mem[readAddr];

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            loaded   <= 1'b0;
            wr_count <= '0;
            overrun  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        wr_count <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        wr_count <= wr_count + 1'b1;
                        if (wr_count == last_idx) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            loaded   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        loaded   <= 1'b0;
                        wr_count <= '0;
                        overrun  <= 1'b0;
                    end else if (in_valid) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    loaded   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tab_table_loader.sv
// tb/tb_tab_table_loader.sv - directed self-checking bench for tab_table_loader
module tb_tab_table_loader;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        loaded;
    logic [8:0]  wr_count;
    logic        overrun;
    logic [7:0]  readAddr;
    logic [31:0] dataOut1;

    int n_total = 0;
    int n_pass  = 0;
    int cyc;
    int bad;

    localparam logic [31:0] tb_image [256] = '{5: 32'hA5A5_A5A5, default: 32'h0};

    tab_table_loader #(.Nloc(256), .Dbits(32), .initfile("init.mem"), .init_image(tb_image)) dut (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .loaded(loaded),
        .wr_count(wr_count), .overrun(overrun), .readAddr(readAddr),
        .dataOut1(dataOut1)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic read_at(input logic [7:0] a, output logic [31:0] d);
        readAddr = a;
        #1;
        d = dataOut1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
    endtask

    // Streams nwords words base+i; bubble drives valid only on odd cycles.
    task automatic stream(input logic [31:0] base, input int nwords, input bit bubble,
                          output int cycles);
        int  i;
        logic rdy;
        i = 0;
        cycles = 0;
        while (i < nwords && cycles < 2000) begin
            in_valid = bubble ? (cycles % 2 == 1) : 1'b1;
            in_data  = base + i;
            rdy = in_ready;
            @(posedge clock);
            if (in_valid && rdy) i++;
            cycles++;
            @(negedge clock);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; readAddr = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst_in_ready", in_ready, 0);
        check("rst_loaded", loaded, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_overrun", overrun, 0);
`ifdef TAB_TABLE_INIT_EN
        read_at(8'd5, d);
        check("init_image_5", d, 32'hA5A5_A5A5);
`endif

        // in_valid in IDLE is ignored
        in_valid = 1'b1; in_data = 32'h1234_5678;
        @(posedge clock); @(negedge clock);
        in_valid = 1'b0;
        check("idle_valid_overrun", overrun, 0);
        check("idle_valid_ready", in_ready, 0);

        // full back-to-back load
        pulse_start();
        check("start_ready_rise", in_ready, 1);
        stream(32'h1000_0000, 256, 1'b0, cyc);
        check("full_cycles", cyc, 256);
        check("full_loaded", loaded, 1);
        check("full_ready_fall", in_ready, 0);
        check("full_wr_count", wr_count, 256);
        read_at(8'h7F, d);
        check("full_rd_7f", d, 32'h1000_007F);
        read_at(8'hFF, d);
        check("full_rd_ff", d, 32'h1000_00FF);

        // bubbled load
        pulse_start();
        check("restart_loaded_drop", loaded, 0);
        stream(32'h2000_0000, 256, 1'b1, cyc);
        check("bubble_cycles", cyc, 512);
        check("bubble_loaded", loaded, 1);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            read_at(8'(i), d);
            if (d !== 32'h2000_0000 + 32'(i)) bad++;
        end
        check("bubble_bad_locations", bad, 0);

        // overrun in DONE
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        @(posedge clock); @(negedge clock);
        in_valid = 1'b0;
        check("overrun_set", overrun, 1);
        check("overrun_wr_count", wr_count, 256);
        read_at(8'h00, d);
        check("overrun_rd_00", d, 32'h2000_0000);
        read_at(8'hFF, d);
        check("overrun_rd_ff", d, 32'h2000_00FF);

        // start and in_valid together in DONE: start wins
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        pulse_start();
        in_valid = 1'b0;
        check("start_clr_overrun", overrun, 0);
        check("start_clr_wr_count", wr_count, 0);
        check("start_ready", in_ready, 1);
        read_at(8'h00, d);
        check("start_no_write", d, 32'h2000_0000);

        // partial load, start ignored in LOAD, then reset
        stream(32'h3000_0000, 100, 1'b0, cyc);
        check("partial_wr_count", wr_count, 100);
        read_at(8'd99, d);
        check("partial_rd_99", d, 32'h3000_0063);
        read_at(8'd100, d);
        check("partial_rd_100_old", d, 32'h2000_0064);
        pulse_start();
        check("load_start_ignored", wr_count, 100);
        reset = 1'b1;
        @(posedge clock); @(negedge clock);
        reset = 1'b0;
        check("midrst_ready", in_ready, 0);
        check("midrst_loaded", loaded, 0);
        check("midrst_wr_count", wr_count, 0);
        read_at(8'd0, d);
        check("midrst_rd_0", d, 32'h3000_0000);
        read_at(8'd99, d);
        check("midrst_rd_99", d, 32'h3000_0063);

        // full reload after reset
        pulse_start();
        stream(32'h4000_0000, 256, 1'b0, cyc);
        check("reload_cycles", cyc, 256);
        check("reload_loaded", loaded, 1);
        read_at(8'h80, d);
        check("reload_rd_80", d, 32'h4000_0080);
        read_at(8'd50, d);
        check("reload_rd_50", d, 32'h4000_0032);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
